mmu_icache_ctrl: RTL

Parametrised instruction-side memory management unit: a direct-mapped, read-only instruction cache with a line-refill state machine in front of a handshaked instruction memory port. It sits between the fetch stage and instruction memory. It drives `nostall` low while a miss is serviced and returns the fetched word on `dataout`. It supersedes the fixed single-word instruction MMU with configurable geometry, multi-word line refill, critical-word-first ordering and a variable-latency memory handshake.

---
 rtl/mmu_icache_ctrl_if.sv | 26 ++
 rtl/mmu_icache_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mmu_icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache controller.
// slave: the cache controller. master: the fetch stage plus memory model.
interface mmu_icache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ren;
  logic [ADDR_W-1:0] addy;
  logic              flush;
  logic              nostall;
  logic [DATA_W-1:0] dataout;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output ren, addy, flush, mem_ack, mem_rdata,
    input  nostall, dataout, mem_req, mem_addr
  );

  modport slave (
    input  ren, addy, flush, mem_ack, mem_rdata,
    output nostall, dataout, mem_req, mem_addr
  );
endinterface

// File: rtl/mmu_icache_ctrl.sv
// Direct-mapped read-only instruction cache with critical-word-first line
// refill over a variable-latency memory handshake.
// Optional feature macro: MMU_ICACHE_CRITICAL_FWD_EN forwards the critical
// word to fetch in the cycle it is acked.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | serving hits; a miss with ren=1 captures the address -> FILL
// FILL  | requesting line words k, k+1, ... (mod WORDS); the last ack
//       | writes the tag, sets valid unless poisoned, and returns to IDLE
module mmu_icache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input logic            clk,
  input logic            reset,
  mmu_icache_ctrl_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES][WORDS];

  logic [TAG_W-1:0] cap_tag;
  logic [IDX_W-1:0] cap_idx;
  logic [OFF_W-1:0] k_q;
  // words still to be acked after the current one; zero means last word
  logic [OFF_W-1:0] remain_q;
  logic             poison_q;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             start_fill;
  logic             fill_wr;
  logic             fill_done;
  logic             nostall_c;
  logic [DATA_W-1:0] dataout_c;
  logic             mem_req_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic             fwd;

  // byte-lane bits of the fetch address carry no information for word fetches
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.addy[1:0];

  assign req_off = bus.addy[2 +: OFF_W];
  assign req_idx = bus.addy[2 + OFF_W +: IDX_W];
  assign req_tag = bus.addy[ADDR_W-1 -: TAG_W];

  assign hit = bus.ren && (state_q == IDLE) && valid_q[req_idx] &&
               (tag_mem[req_idx] == req_tag);

`ifdef MMU_ICACHE_CRITICAL_FWD_EN
  logic [OFF_W-1:0] cap_off;

  // only the first ack of a fill carries the word the fetch stage missed on
  assign fwd = (state_q == FILL) && bus.mem_ack &&
               (remain_q == OFF_W'(WORDS - 1)) && bus.ren &&
               (bus.addy[ADDR_W-1:2] == {cap_tag, cap_idx, cap_off});

  // remember which word the fill was started for
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_off <= '0;
    end else if (start_fill) begin
      cap_off <= req_off;
    end
  end
`else
  assign fwd = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, memory handshake and fetch-side outputs
  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    fill_wr    = 1'b0;
    fill_done  = 1'b0;
    mem_req_c  = 1'b0;
    mem_addr_c = '0;
    dataout_c  = '0;
    nostall_c  = (state_q == IDLE) && !(bus.ren && !hit);
    if (hit) begin
      dataout_c = data_mem[req_idx][req_off];
    end
    if (fwd) begin
      dataout_c = bus.mem_rdata;
      nostall_c = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (bus.ren && !hit) begin
          start_fill = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        mem_req_c  = 1'b1;
        mem_addr_c = {cap_tag, cap_idx, k_q, 2'b00};
        if (bus.mem_ack) begin
          fill_wr = 1'b1;
          if (remain_q == '0) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // fill bookkeeping, valid bits and flush poisoning
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      cap_tag  <= '0;
      cap_idx  <= '0;
      k_q      <= '0;
      remain_q <= '0;
      poison_q <= 1'b0;
    end else begin
      if (start_fill) begin
        cap_tag  <= req_tag;
        cap_idx  <= req_idx;
        k_q      <= req_off;
        remain_q <= OFF_W'(WORDS - 1);
        poison_q <= 1'b0;
      end
      if (fill_wr) begin
        k_q      <= k_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end
      if (bus.flush && (state_q == FILL)) begin
        poison_q <= 1'b1;
      end
      // a flush arriving on the last ack still wins over setting valid
      if (bus.flush) begin
        valid_q <= '0;
      end else if (fill_done && !poison_q) begin
        valid_q[cap_idx] <= 1'b1;
      end
    end
  end

  // line storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_mem[cap_idx][k_q] <= bus.mem_rdata;
    end
    if (fill_done) begin
      tag_mem[cap_idx] <= cap_tag;
    end
  end

  assign bus.nostall  = nostall_c;
  assign bus.dataout  = dataout_c;
  assign bus.mem_req  = mem_req_c;
  assign bus.mem_addr = mem_addr_c;
endmodule
